// File: rtl/instr_ctrl_pkg.sv
// Shared encodings for the instruction fetch/decode controller: FSM states,
// major opcodes, ALU opcodes and instruction field positions.
package instr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RETIRE = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_OR  = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SLT = 2'd3
    } alu_op_e;

    localparam logic [3:0] MAJ_NOP  = 4'd0;
    localparam logic [3:0] MAJ_ALU  = 4'd1;
    localparam logic [3:0] MAJ_HALT = 4'd15;

    localparam int RS1_LSB   = 0;
    localparam int RS2_LSB   = 2;
    localparam int RD_LSB    = 4;
    localparam int ALUOP_LSB = 6;
    localparam int BINV_BIT  = 8;
    localparam int RSVD_LSB  = 9;
    localparam int MAJOR_LSB = 12;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and legality check of the instruction register.
// Zero latency; no flow control.
module instr_decode
    import instr_ctrl_pkg::*;
#(
    parameter int IW = 16
)(
    input  logic [IW-1:0] ir_i,
    output logic [1:0]    rs1_o,
    output logic [1:0]    rs2_o,
    output logic [1:0]    rd_o,
    output logic [1:0]    alu_op_o,
    output logic          binv_o,
    output logic          is_alu_o,
    output logic          is_halt_o,
    output logic          illegal_o
);

    logic [3:0] major;
    logic [2:0] unused_rsvd;

    assign major       = ir_i[MAJOR_LSB +: 4];
    assign unused_rsvd = ir_i[RSVD_LSB +: 3];

    assign rs1_o    = ir_i[RS1_LSB +: 2];
    assign rs2_o    = ir_i[RS2_LSB +: 2];
    assign rd_o     = ir_i[RD_LSB +: 2];
    assign alu_op_o = ir_i[ALUOP_LSB +: 2];
    assign binv_o   = ir_i[BINV_BIT];

    assign is_alu_o  = (major == MAJ_ALU);
    assign is_halt_o = (major == MAJ_HALT);
    assign illegal_o = !(is_alu_o || is_halt_o || (major == MAJ_NOP));

endmodule

// File: rtl/instr_ctrl.sv
// Multi-cycle fetch/decode sequencer: FETCH (req/ack, timeout) -> DECODE -> READ -> WRITE -> RETIRE.
// ALU instruction = fetch wait + 4 cycles; fetch stalls on imem_ack until FETCH_TIMEOUT, then FAULT.
module instr_ctrl
    import instr_ctrl_pkg::*;
#(
    parameter int AW            = 4,
    parameter int IW            = 16,
    parameter int FETCH_TIMEOUT = 15,
    parameter int RCNT_W        = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     pc_addr,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [IW-1:0]     imem_rdata,
    output logic [IW-1:0]     instruction,
    output logic [1:0]        opcode,
    output logic              binv,
    output logic              rw,
    output logic              pc_inc,
    output logic              halted,
    output logic              fault,
    output logic [RCNT_W-1:0] retired
);

    localparam int            TW       = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [RCNT_W-1:0] ret_q, ret_d;
    alu_op_e           op_q, op_d;
    logic              binv_q, binv_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              req_en_q;

    logic [1:0] dec_rs1, dec_rs2, dec_rd, dec_alu_op;
    logic       dec_binv, dec_is_alu, dec_is_halt, dec_illegal;
    logic       unused_fields;

    instr_decode #(.IW(IW)) u_decode (
        .ir_i      (ir_q),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .alu_op_o  (dec_alu_op),
        .binv_o    (dec_binv),
        .is_alu_o  (dec_is_alu),
        .is_halt_o (dec_is_halt),
        .illegal_o (dec_illegal)
    );

    // Register operands are routed to the datapath straight from the IR.
    assign unused_fields = ^{dec_rs1, dec_rs2, dec_rd};

    assign instruction = ir_q;
    assign opcode      = op_q;
    assign binv        = binv_q;
    assign retired     = ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            tmo_q    <= '0;
            ret_q    <= '0;
            op_q     <= ALU_AND;
            binv_q   <= 1'b0;
            addr_q   <= '0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            tmo_q    <= tmo_d;
            ret_q    <= ret_d;
            op_q     <= op_d;
            binv_q   <= binv_d;
            addr_q   <= addr_d;
            req_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        tmo_d     = tmo_q;
        ret_d     = ret_q;
        op_d      = op_q;
        binv_d    = binv_q;
        addr_d    = addr_q;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        rw        = 1'b1;
        pc_inc    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // First FETCH cycle: present the live PC and capture it for the rest of the wait.
                if (tmo_q == '0) begin
                    addr_d = pc_addr;
                    if (req_en_q) imem_addr = pc_addr;
                end
                if (req_en_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_d    = imem_rdata;
                        tmo_d   = '0;
                        state_d = ST_DECODE;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_d   = '0;
                        state_d = ST_FAULT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_FAULT;
                end else if (dec_is_alu) begin
                    op_d    = alu_op_e'(dec_alu_op);
                    binv_d  = dec_binv;
                    state_d = ST_READ;
                end else if (dec_is_halt) begin
                    ret_d   = ret_q + RCNT_W'(1);
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RETIRE;
                end
            end
            ST_READ: state_d = ST_WRITE;
            ST_WRITE: begin
                rw      = 1'b0;
                state_d = ST_RETIRE;
            end
            ST_RETIRE: begin
                pc_inc  = 1'b1;
                ret_d   = ret_q + RCNT_W'(1);
                state_d = ST_FETCH;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  state_d = ST_FAULT;
        endcase
    end

endmodule
